// File: rtl/cle188_sdwr.sv
// cle188_sdwr: bus-mapped serial write engine that shifts a byte out MSB-first on SDWR/SCLK/SDSEL_N.
// Define CLE188_SDWR_READBACK_EN to add the STATUS register, BD_OUT/BD_OE drive and OVERRUN flag.
module cle188_sdwr #(
  parameter int DIV = 2  // clk cycles per serial half-bit phase, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SSER,
  input  logic       BA13,
  input  logic       BA12,
  input  logic [3:0] BA,
  input  logic       BR_W,
  input  logic [7:0] BD_IN,
  output logic [7:0] BD_OUT,
  output logic       BD_OE,
  output logic       SDWR,
  output logic       SCLK,
  output logic       SDSEL_N,
  output logic       BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD} state_t;

  localparam logic [3:0] PHASE_LAST = 4'(DIV - 1);

  logic       w_sel;
  logic       r_sel;
  logic       r_acc;
  logic [3:0] r_ba;
  logic       r_rw;
  logic [7:0] r_din;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_phase;
  logic       w_phase_done;
  logic [7:0] r_shreg;
  logic [2:0] r_bitcnt;
  logic       r_sdsel_n;
  logic       r_hold_cs;

  logic       w_data_wr;
  logic       w_ctrl_wr;

  assign w_sel = ~SSER & ~BA13 & BA12;

  // The access is captured on the edge sel is first seen, and acted on one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel <= 1'b0;
      r_acc <= 1'b0;
      r_ba  <= 4'h0;
      r_rw  <= 1'b1;
      r_din <= 8'h00;
    end else begin
      r_sel <= w_sel;
      r_acc <= w_sel & ~r_sel;
      r_ba  <= BA;
      r_rw  <= BR_W;
      r_din <= BD_IN;
    end
  end

  assign w_data_wr    = r_acc & ~r_rw & (r_ba == 4'h0);
  assign w_ctrl_wr    = r_acc & ~r_rw & (r_ba == 4'h1);
  assign w_phase_done = (r_phase == 4'h0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_data_wr) w_state_next = S_SETUP;
      S_SETUP: if (w_phase_done) w_state_next = S_HIGH;
      S_HIGH:  if (w_phase_done) w_state_next = (r_bitcnt == 3'd0) ? S_HOLD : S_LOW;
      S_LOW:   if (w_phase_done) w_state_next = S_HIGH;
      S_HOLD:  if (w_phase_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_phase   <= PHASE_LAST;
      r_shreg   <= 8'hFF;
      r_bitcnt  <= 3'd7;
      r_sdsel_n <= 1'b1;
      r_hold_cs <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state != w_state_next)
        r_phase <= PHASE_LAST;
      else if (!w_phase_done)
        r_phase <= r_phase - 4'd1;

      case (r_state)
        S_IDLE: begin
          if (w_data_wr) begin
            r_shreg   <= r_din;
            r_bitcnt  <= 3'd7;
            r_sdsel_n <= 1'b0;
          end else if (w_ctrl_wr && r_din[1]) begin
            r_sdsel_n <= 1'b1;
          end
        end
        S_HIGH: begin
          if (w_phase_done && (r_bitcnt != 3'd0)) begin
            r_shreg  <= {r_shreg[6:0], 1'b0};
            r_bitcnt <= r_bitcnt - 3'd1;
          end
        end
        S_HOLD: begin
          if (w_phase_done && !r_hold_cs)
            r_sdsel_n <= 1'b1;
        end
        default: ;
      endcase

      if (w_ctrl_wr)
        r_hold_cs <= r_din[0];
    end
  end

  // shreg is untouched in IDLE, so SDWR keeps the last bit sent.
  assign SDWR    = r_shreg[7];
  assign SCLK    = (r_state == S_HIGH);
  assign SDSEL_N = r_sdsel_n;
  assign BUSY    = (r_state != S_IDLE);

`ifdef CLE188_SDWR_READBACK_EN
  logic       w_stat_rd;
  logic       w_any_rd;
  logic       r_overrun;
  logic       r_oe;
  logic [7:0] r_bdout;

  assign w_stat_rd = r_acc & r_rw & (r_ba == 4'h2);
  assign w_any_rd  = r_acc & r_rw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_oe      <= 1'b0;
      r_bdout   <= 8'h00;
    end else begin
      if (w_data_wr && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      else if (w_stat_rd)
        r_overrun <= 1'b0;

      // Readback value is latched at acceptance, so a clear-on-read still returns the old flag.
      if (w_any_rd) begin
        r_oe    <= 1'b1;
        r_bdout <= w_stat_rd ? {5'b00000, r_hold_cs, r_overrun, BUSY} : 8'h00;
      end else if (!(w_sel & BR_W)) begin
        r_oe <= 1'b0;
      end
    end
  end

  assign BD_OE  = r_oe;
  assign BD_OUT = r_bdout;
`else
  assign BD_OE  = 1'b0;
  assign BD_OUT = 8'h00;
`endif

endmodule
